// File: rtl/ram_ctrl_pkg.sv
// Shared FSM state encoding and request-direction constants for the clocked RAM controller.
package ram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      PIPE   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/ram_clocked_ctrl_tick_divider.sv
// Integer clock-enable divider: counts 0..DIV-1 and pulses tick for the single cycle at DIV-1.
module tick_divider #(
   parameter int unsigned DIV = 2
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   generate
      if (DIV == 0) begin : g_bad_div
         $error("tick_divider: DIV must be at least 1");
      end
   endgenerate

   always_comb begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // Gated so a DIV=1 divider still shows no tick while reset is held.
   assign tick = (cnt_reg == LAST) && !reset;

endmodule

// File: rtl/ram_clocked_ctrl.sv
// Single-clock RAM with valid/ready request/response, three tick enables and a debug capture.
// Build option: define RAM_DEBUG_EN to enable last_read, data_debug capture and tick_c.
module ram_clocked_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DEPTH   = 4096,
   parameter int unsigned OUT_REG = 0,
   parameter int unsigned DIV_A   = 2,
   parameter int unsigned DIV_B   = 50,
   parameter int unsigned DIV_C   = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              tick_a,
   output logic              tick_b,
   output logic              tick_c,
   output logic [DATA_W-1:0] data_debug
);

   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t              state_reg;
   state_t              state_next;
   logic                rw_reg;
   logic [MEM_AW-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                err_reg;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   ram_q;
   logic [DATA_W-1:0]   rd_data;
   logic                accept;
   logic                req_in_range;
   logic                read_ok;

   assign accept       = req_valid && req_ready;
   assign req_in_range = (64'(req_addr) < 64'(DEPTH));
   assign read_ok      = (rw_reg == RW_READ) && !err_reg;

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
      case (state_reg)
         IDLE: begin
            req_ready = !reset;
            if (accept) state_next = ACCESS;
         end
         ACCESS: begin
            state_next = (OUT_REG != 0) ? PIPE : RESP;
         end
         PIPE: begin
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_reg;
            rsp_rdata = read_ok ? rd_data : '0;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         rw_reg    <= RW_READ;
         addr_reg  <= '0;
         wdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rw_reg    <= req_rw;
            addr_reg  <= req_addr[MEM_AW-1:0];
            wdata_reg <= req_wdata;
            err_reg   <= !req_in_range;
         end
      end
   end

   // Memory has no reset so it maps onto block RAM; an access aborted by reset writes nothing.
   always_ff @(posedge clock) begin
      if (state_reg == ACCESS) begin
         if ((rw_reg == RW_WRITE) && !err_reg && !reset) begin
            mem[addr_reg] <= wdata_reg;
         end
         ram_q <= mem[addr_reg];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] pipe_q;
         always_ff @(posedge clock) begin
            if (state_reg == PIPE) pipe_q <= ram_q;
         end
         assign rd_data = pipe_q;
      end else begin : g_no_out_reg
         assign rd_data = ram_q;
      end
   endgenerate

   tick_divider #(.DIV(DIV_A)) u_tick_a (.clock(clock), .reset(reset), .tick(tick_a));
   tick_divider #(.DIV(DIV_B)) u_tick_b (.clock(clock), .reset(reset), .tick(tick_b));

`ifdef RAM_DEBUG_EN
   logic [DATA_W-1:0] last_read_reg;
   logic [DATA_W-1:0] data_debug_reg;

   tick_divider #(.DIV(DIV_C)) u_tick_c (.clock(clock), .reset(reset), .tick(tick_c));

   // A read accepted in the same cycle as tick_c lands after the capture, so the old value is shown.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_read_reg  <= '0;
         data_debug_reg <= '0;
      end else begin
         if (tick_c) data_debug_reg <= last_read_reg;
         if ((state_reg == RESP) && rsp_ready && read_ok) last_read_reg <= rd_data;
      end
   end

   assign data_debug = data_debug_reg;
`else
   generate
      if (DIV_C == 0) begin : g_bad_div_c
         $error("ram_clocked_ctrl: DIV_C must be at least 1");
      end
   endgenerate

   assign tick_c     = 1'b0;
   assign data_debug = '0;
`endif

endmodule
